line_proc_stream: RTL

Parametrised per-line pixel processor between the line-buffer reader and the line-buffer writer of the image pipeline. On each `READ_LINE_DONE` it issues a run-time-configurable number of read beats (`IN_DE`) and applies a per-pixel colour operation. It emits the processed pixels with `OUT_DE` through a fixed-latency pipeline and pulses `WRITE_LINE_DONE` on the last output beat. It adds read-latency compensation, one-deep request queuing, a line counter and overrun detection.

---
 rtl/line_proc_stream_if.sv | 31 +++
 rtl/line_proc_stream.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/line_proc_stream_if.sv
// Handshake/bus bundle for line_proc_stream.
//   master : the line processor (drives read strobes and processed pixels)
//   slave  : the surrounding pipeline (line-ready pulse, config, read data)
// Signals: CFG_WIDTH/CFG_MODE line config, READ_LINE_DONE line-ready pulse,
//   IN_DE/IN_DATA read side, OUT_DE/OUT_DATA/WRITE_LINE_DONE write side,
//   BUSY/LINE_CNT/ERR_OVERRUN status.
interface line_proc_stream_if #(
  parameter int W_BITS = 12,
  parameter int LCNT_W = 16
);
  logic [W_BITS-1:0] CFG_WIDTH;
  logic [1:0]        CFG_MODE;
  logic              READ_LINE_DONE;
  logic              IN_DE;
  logic [31:0]       IN_DATA;
  logic              OUT_DE;
  logic [31:0]       OUT_DATA;
  logic              WRITE_LINE_DONE;
  logic              BUSY;
  logic [LCNT_W-1:0] LINE_CNT;
  logic              ERR_OVERRUN;

  modport master (
    input  CFG_WIDTH, CFG_MODE, READ_LINE_DONE, IN_DATA,
    output IN_DE, OUT_DE, OUT_DATA, WRITE_LINE_DONE, BUSY, LINE_CNT, ERR_OVERRUN
  );
  modport slave (
    output CFG_WIDTH, CFG_MODE, READ_LINE_DONE, IN_DATA,
    input  IN_DE, OUT_DE, OUT_DATA, WRITE_LINE_DONE, BUSY, LINE_CNT, ERR_OVERRUN
  );
endinterface

// File: rtl/line_proc_stream.sv
// Per-line pixel processor between line-buffer reader and writer.
// On READ_LINE_DONE it issues W read beats (IN_DE), applies a colour op to
// each pixel RD_LAT cycles later and emits it on OUT_DE one cycle after that.
// WRITE_LINE_DONE marks the last output beat; one extra request is queued,
// further requests while one is queued set the sticky ERR_OVERRUN.
// Ports: CLK, RST (sync, active-high), bus (line_proc_stream_if.master).
// Optional build: define LINE_PROC_GRAY_EN to build the grayscale mode (2);
// without it mode 2 passes pixels through unchanged.
module line_proc_stream #(
  parameter int RD_LAT = 1,   // 0..4
  parameter int W_BITS = 12,
  parameter int LCNT_W = 16
) (
  input  logic CLK,
  input  logic RST,
  line_proc_stream_if.master bus
);
  localparam logic [W_BITS-1:0] ONE = {{(W_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [W_BITS-1:0] w_q, cnt_q;
  logic [1:0]        m_q;
  logic              pend_q, err_q, in_de_q, busy_q;
  logic              out_de_q, wld_q;
  logic [31:0]       out_data_q, out_data_d;
  logic [LCNT_W-1:0] lcnt_q;
  logic              start, in_last, wld_d;
  logic [7:0]        pa, pr, pg, pb;

  // Beat-valid and last-beat flags, index k = k cycles after the IN_DE beat.
  logic [RD_LAT:0]   de_sr, lst_sr;

  assign start   = (state_q == IDLE) && (bus.READ_LINE_DONE || pend_q);
  assign in_last = in_de_q && (cnt_q == w_q - ONE);

  assign de_sr[0]  = in_de_q;
  assign lst_sr[0] = in_last;

  if (RD_LAT > 0) begin : g_lat
    logic [RD_LAT-1:0] de_q, lst_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        de_q  <= '0;
        lst_q <= '0;
      end else begin
        de_q  <= de_sr[RD_LAT-1:0];
        lst_q <= lst_sr[RD_LAT-1:0];
      end
    end
    assign de_sr[RD_LAT:1]  = de_q;
    assign lst_sr[RD_LAT:1] = lst_q;
  end

  // Control FSM. DONE coincides with the last output beat, so the drain
  // period after the final read beat is RD_LAT cycles of DRAIN plus DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      w_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      in_de_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          w_q    <= bus.CFG_WIDTH;
          m_q    <= bus.CFG_MODE;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          if (bus.CFG_WIDTH != '0) begin
            state_q <= RUN;
            in_de_q <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        RUN: begin
          if (in_last) begin
            in_de_q <= 1'b0;
            state_q <= (RD_LAT == 0) ? DONE : DRAIN;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        DRAIN: if (lst_sr[RD_LAT]) state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-deep request queue. In IDLE a queued request is consumed by the
  // start; a fresh pulse arriving in that same cycle takes its place.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      pend_q <= pend_q && bus.READ_LINE_DONE;
    end else if (bus.READ_LINE_DONE) begin
      if (pend_q) err_q <= 1'b1;
      pend_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) lcnt_q <= '0;
    else if (state_q == DONE) lcnt_q <= lcnt_q + 1'b1;
  end

  // Pixel stage
  assign pa = bus.IN_DATA[31:24];
  assign pr = bus.IN_DATA[23:16];
  assign pg = bus.IN_DATA[15:8];
  assign pb = bus.IN_DATA[7:0];

`ifdef LINE_PROC_GRAY_EN
  logic [15:0] y16;
  logic [7:0]  gray;
  assign y16  = 16'd77 * {8'd0, pr} + 16'd150 * {8'd0, pg} + 16'd29 * {8'd0, pb};
  assign gray = 8'(y16 >> 8);
`endif

  always_comb begin
    out_data_d = bus.IN_DATA;
    case (m_q)
      2'd1: out_data_d = {pa, ~pr, ~pg, ~pb};
`ifdef LINE_PROC_GRAY_EN
      2'd2: out_data_d = {pa, gray, gray, gray};
`endif
      2'd3: out_data_d = {pa, pb, pg, pr};
      default: ;
    endcase
  end

  // Zero-width lines report completion in their DONE cycle with no data.
  assign wld_d = lst_sr[RD_LAT] || (start && (bus.CFG_WIDTH == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_de_q   <= 1'b0;
      out_data_q <= '0;
      wld_q      <= 1'b0;
    end else begin
      out_de_q <= de_sr[RD_LAT];
      wld_q    <= wld_d;
      if (de_sr[RD_LAT]) out_data_q <= out_data_d;
    end
  end

  assign bus.IN_DE           = in_de_q;
  assign bus.OUT_DE          = out_de_q;
  assign bus.OUT_DATA        = out_data_q;
  assign bus.WRITE_LINE_DONE = wld_q;
  assign bus.BUSY            = busy_q;
  assign bus.LINE_CNT        = lcnt_q;
  assign bus.ERR_OVERRUN     = err_q;
endmodule
